// File: rtl/icache_ctrl.sv
// icache_ctrl -- sequencing controller for a direct-mapped, 256-set
// instruction cache (one 256-bit data-line RAM + one {valid,tag} RAM).
//
// Serializes three kinds of RAM traffic so the RAMs never see a read and a
// write in the same cycle:
//   - post-reset valid-clear sweep (INIT, 256 cycles)
//   - CPU lookup reads (IDLE -> LOOKUP)
//   - refill writes after a miss (ASKMEM -> WAITMEM -> REFILL)
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   cpu_req_*/cpu_addr      fetch request (valid/ready)
//   cpu_rsp_*               one-cycle response pulse + instruction word
//   ram_rd_*                read strobe/set, line + {valid,tag} one cycle later
//   ram_wr_*                write strobe/set/line/{valid,tag}
//   mem_req_*/mem_addr      line-read request to the memory bus
//   mem_rsp_*               refill line from the memory bus
//
// Optional feature: define ICACHE_PERF_CNT_EN to add 32-bit hit_cnt and
// miss_cnt outputs, counting LOOKUP hits and misses (wrapping).
module icache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 5,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_rsp_valid,
    output logic [31:0]        cpu_rsp_data,
    output logic               ram_rd_en,
    output logic [INDEX_W-1:0] ram_rd_addr,
    input  logic [255:0]       ram_rd_line,
    input  logic [TAG_W:0]     ram_rd_tagv,
    output logic               ram_wr_en,
    output logic [INDEX_W-1:0] ram_wr_addr,
    output logic [255:0]       ram_wr_line,
    output logic [TAG_W:0]     ram_wr_tagv,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rsp_valid,
    input  logic [255:0]       mem_rsp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LOOKUP  = 3'd2;
    localparam logic [2:0] S_ASKMEM  = 3'd3;
    localparam logic [2:0] S_WAITMEM = 3'd4;
    localparam logic [2:0] S_REFILL  = 3'd5;

    logic [2:0]         state;
    logic [INDEX_W-1:0] sweep_cnt;
    logic [ADDR_W-1:0]  req_addr;
    logic [7:0][31:0]   line_buf;
    logic [7:0][31:0]   rd_words;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [2:0]         word_sel;
    logic               accept;
    logic               hit;

    assign req_tag   = req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
    assign req_index = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign word_sel  = req_addr[OFFSET_W-1:2];
    assign rd_words  = ram_rd_line;

    // Byte offset within the word never matters for word fetches.
    logic unused_lsb;
    assign unused_lsb = ^req_addr[1:0];

    assign cpu_req_ready = (state == S_IDLE);
    assign accept        = cpu_req_ready && cpu_req_valid;
    assign hit           = ram_rd_tagv[TAG_W] && (ram_rd_tagv[TAG_W-1:0] == req_tag);

    // Lookup read is issued in the accept cycle straight from cpu_addr.
    assign ram_rd_en   = accept;
    assign ram_rd_addr = cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];

    // Reset gates the write strobe so INIT's state value never writes while
    // reset is held, and an in-flight refill write is dropped immediately.
    assign ram_wr_en   = ((state == S_INIT) || (state == S_REFILL)) && reset;
    assign ram_wr_addr = (state == S_INIT) ? sweep_cnt : req_index;
    assign ram_wr_line = (state == S_INIT) ? '0 : line_buf;
    assign ram_wr_tagv = (state == S_INIT) ? '0 : {1'b1, req_tag};

    assign mem_req_valid = (state == S_ASKMEM);
    // Derived from the latched request, so it is stable through ASKMEM.
    assign mem_addr      = {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_INIT;
            sweep_cnt     <= '0;
            req_addr      <= '0;
            line_buf      <= '0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_data  <= '0;
        end else begin
            cpu_rsp_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (accept) begin
                        req_addr <= cpu_addr;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        cpu_rsp_data  <= rd_words[word_sel];
                        cpu_rsp_valid <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        state <= S_ASKMEM;
                    end
                end
                S_ASKMEM: begin
                    if (mem_req_ready) state <= S_WAITMEM;
                end
                S_WAITMEM: begin
                    if (mem_rsp_valid) begin
                        line_buf <= mem_rsp_data;
                        state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    cpu_rsp_data  <= line_buf[word_sel];
                    cpu_rsp_valid <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit) hit_cnt  <= hit_cnt + 1'b1;
            else     miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl: behavioural RAM model, hand-driven
// memory bus, cycle-exact checks relative to the request accept edge.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic [31:0]  cpu_addr = '0;
    logic         cpu_rsp_valid;
    logic [31:0]  cpu_rsp_data;
    logic         ram_rd_en;
    logic [7:0]   ram_rd_addr;
    logic [255:0] ram_rd_line;
    logic [19:0]  ram_rd_tagv;
    logic         ram_wr_en;
    logic [7:0]   ram_wr_addr;
    logic [255:0] ram_wr_line;
    logic [19:0]  ram_wr_tagv;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [255:0] mem_rsp_data = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_line(ram_rd_line), .ram_rd_tagv(ram_rd_tagv),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_line(ram_wr_line), .ram_wr_tagv(ram_wr_tagv),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // RAM model: 1-cycle read latency, no reset.
    logic [255:0] dram [256];
    logic [19:0]  tram [256];
    int overlap = 0;
    int vwr_cnt = 0;   // writes carrying a set valid bit (refills)

    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rd_line <= dram[ram_rd_addr];
            ram_rd_tagv <= tram[ram_rd_addr];
        end
        if (ram_wr_en) begin
            dram[ram_wr_addr] <= ram_wr_line;
            tram[ram_wr_addr] <= ram_wr_tagv;
            if (ram_wr_tagv[19]) vwr_cnt <= vwr_cnt + 1;
        end
        if (ram_rd_en && ram_wr_en) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + w;
        return l;
    endfunction

    // Call with time just after reset release (off the clock edge).
    task automatic check_sweep(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!(ram_wr_en === 1'b1 && ram_wr_addr === i[7:0] && ram_wr_tagv === 20'h0 &&
                  cpu_req_ready === 1'b0 && ram_rd_en === 1'b0))
                bad++;
            @(negedge clk);
        end
        chk({tag, "_bad_cycles"}, bad, 0);
        chk({tag, "_ready_c256"}, cpu_req_ready, 1);
        chk({tag, "_wr_done"}, ram_wr_en, 0);
    endtask

    // One fetch; k counts cycles after the accept edge (k=1 is LOOKUP).
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_data, input bit exp_hit,
                         input int req_dly, input int rsp_dly, input bit stray,
                         input logic [31:0] base);
        logic [255:0] line;
        int req_first, hs_k, wr_k, rsp_k, wr_cnt, wr_bad, addr_bad;
        logic [31:0] got;
        line = mk_line(base);
        req_first = -1; hs_k = -1; wr_k = -1; rsp_k = -1;
        wr_cnt = 0; wr_bad = 0; addr_bad = 0; got = '0;
        @(negedge clk);
        chk("rsp_is_pulse", cpu_rsp_valid, 0);
        chk("req_ready", cpu_req_ready, 1);
        cpu_addr = a;
        cpu_req_valid = 1'b1;
        #1;
        chk("rd_en_at_accept", ram_rd_en, 1);
        chk("rd_addr_at_accept", ram_rd_addr, a[12:5]);
        for (int k = 1; k <= 100 && rsp_k < 0; k++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            if (mem_req_valid) begin
                if (req_first < 0) req_first = k;
                if (mem_addr !== {a[31:5], 5'b0}) addr_bad++;
            end
            if (ram_wr_en) begin
                wr_cnt++;
                wr_k = k;
                if (ram_wr_addr !== a[12:5] || ram_wr_tagv !== {1'b1, a[31:13]} ||
                    ram_wr_line !== line)
                    wr_bad++;
            end
            if (cpu_rsp_valid) begin
                rsp_k = k;
                got = cpu_rsp_data;
                chk("ready_at_rsp", cpu_req_ready, 1);
            end
            mem_req_ready = (req_first >= 0) && (hs_k < 0) && (k >= req_first + req_dly);
            if (mem_req_valid && mem_req_ready) hs_k = k;
            mem_rsp_valid = (stray && k == 1) || (hs_k >= 0 && k == hs_k + 1 + rsp_dly);
            mem_rsp_data  = (stray && k == 1) ? mk_line(32'hDEAD0000) : line;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk("rsp_data", got, exp_data);
        chk("rsp_cycle", rsp_k, exp_hit ? 2 : 5 + req_dly + rsp_dly);
        chk("memreq_first", req_first, exp_hit ? -1 : 2);
        chk("mem_addr_stable", addr_bad, 0);
        chk("refill_writes", wr_cnt, exp_hit ? 0 : 1);
        chk("refill_content", wr_bad, 0);
        chk("refill_cycle", wr_k, exp_hit ? -1 : 4 + req_dly + rsp_dly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int vwr_before;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cpu_req_ready, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_mem_req", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", cpu_rsp_valid, 0);
        chk("rst_rsp_data", cpu_rsp_data, 0);
        reset = 1'b1;
        #1;
        check_sweep("sweep1");

        // Cold miss, set 0x05, word 1
        fetch(32'h1C0000A4, 32'h0000_1001, 1'b0, 0, 0, 1'b0, 32'h1000);
        // Hit on same line, word 2
        fetch(32'h1C0000A8, 32'h0000_1002, 1'b1, 0, 0, 1'b0, 32'h0);
        // Conflict miss on set 0x05, word 0
        fetch(32'h2C0000A0, 32'h0000_2000, 1'b0, 0, 0, 1'b0, 32'h2000);
        // Original line was evicted
        fetch(32'h1C0000A4, 32'h0000_3001, 1'b0, 0, 0, 1'b0, 32'h3000);
        // Stalled bus plus stray response during LOOKUP
        fetch(32'h2C0000A8, 32'h0000_4002, 1'b0, 5, 7, 1'b1, 32'h4000);
        fetch(32'h2C0000BC, 32'h0000_4007, 1'b1, 0, 0, 1'b0, 32'h0);
        // Last set, last word; tag 0 must not hit a swept (invalid) entry
        fetch(32'h00001FFC, 32'h0000_5007, 1'b0, 0, 0, 1'b0, 32'h5000);
        fetch(32'h00001FE0, 32'h0000_5000, 1'b1, 0, 0, 1'b0, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, 3);
        chk("miss_cnt", miss_cnt, 5);
`endif

        // Reset during WAITMEM
        vwr_before = vwr_cnt;
        @(negedge clk);
        cpu_addr = 32'h3C0000A4;
        cpu_req_valid = 1'b1;
        @(negedge clk);              // k=1 LOOKUP
        cpu_req_valid = 1'b0;
        @(negedge clk);              // k=2 ASKMEM
        chk("rst_test_askmem", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);              // k=3 WAITMEM
        mem_req_ready = 1'b0;
        chk("rst_test_waitmem", mem_req_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = mk_line(32'h6000);
        #1;
        chk("midrst_mem_req", mem_req_valid, 0);
        chk("midrst_wr_en", ram_wr_en, 0);
        chk("midrst_ready", cpu_req_ready, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ram_wr_en !== 1'b0 || mem_req_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) bad++;
        end
        chk("midrst_quiet", bad, 0);
        chk("midrst_rsp_data", cpu_rsp_data, 0);
`ifdef ICACHE_PERF_CNT_EN
        chk("midrst_hit_cnt", hit_cnt, 0);
        chk("midrst_miss_cnt", miss_cnt, 0);
`endif
        mem_rsp_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_sweep("sweep2");
        chk("no_refill_write", vwr_cnt - vwr_before, 0);
        // Everything invalid again after the sweep
        fetch(32'h2C0000BC, 32'h0000_7007, 1'b0, 0, 0, 1'b0, 32'h7000);
        chk("rd_wr_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
